regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Owns the single write port of the 8-entry architectural register file data array.
//  Clears every register after reset, then shares the port between NUM_REQ writers.
//  Writers are commit/writeback sources; the grant is round-robin.
//  Sits between the writers and the register file's load/dest/in inputs.
//  Read ports are untouched.
// PARAMETERS
//  NUM_REQ     2   number of write requesters (>=2)
//  data_width  16  register data width
//  tag_width   3   register index width; INIT clears 2**tag_width entries
// PORTS
//  clk        in   1                    system clock, all state on posedge
//  rst        in   1                    synchronous, active-high reset
//  req        in   NUM_REQ              req[i]: requester i wants a write this cycle
//  wr_dest    in   NUM_REQ*tag_width    slice i = destination register of requester i
//  wr_data    in   NUM_REQ*data_width   slice i = write data of requester i
//  ack        out  NUM_REQ              one-hot grant; write happens at this clk edge
//  rf_load    out  1                    to register file load
//  rf_dest    out  tag_width            to register file dest
//  rf_in      out  data_width           to register file in
//  init_busy  out  1                    high while clear sequence runs (or rst high)
// BEHAVIOUR
//  Clock and reset
//   - One clock: clk. rst is synchronous and active-high.
//   - rst at a posedge: state=INIT, clr_cnt=0, rr_ptr=0.
//  Outputs while rst is high
//   - rf_load=0, ack=0, init_busy=1.
//   - rf_dest=0, rf_in=0.
//  State INIT
//   - rf_load=1, rf_dest=clr_cnt, rf_in=0, ack=0, init_busy=1.
//   - clr_cnt increments each cycle.
//   - When clr_cnt == 2**tag_width-1, the next state is RUN.
//   - INIT lasts exactly 2**tag_width cycles. req is ignored and never acked.
//  State RUN
//   - init_busy=0. Grant is combinational from req and rr_ptr (zero latency).
//   - Winner: first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - ack[winner]=1, rf_load=1, rf_dest=wr_dest[winner], rf_in=wr_data[winner].
//   - The register file writes at the same edge.
//   - No req: ack=0, rf_load=0, rf_dest=0, rf_in=0. rr_ptr holds.
//   - On a grant, rr_ptr <= (winner+1) mod NUM_REQ at the edge.
//   - Single requester: granted every cycle it requests.
//  Handshake
//   - A requester holds req, wr_dest and wr_data stable until it sees ack.
//   - The ack cycle completes the transfer; the requester may drop req or present new data next cycle.
//   - ack is never asserted without the matching req.
//  Throughput, fairness and ordering
//   - Max one write per cycle.
//   - A requester waits at most NUM_REQ-1 granted cycles.
//   - Two requesters to the same dest in consecutive cycles: the later write wins.
//  rst mid-operation
//   - Any in-flight (un-acked) request is dropped.
//   - The clear sequence restarts from register 0; rr_ptr returns to 0.
//  No other state: no FIFOs, no buffering of data.
// TESTING
//  1. rst 1 cycle, then idle -> 8 cycles rf_load=1, rf_dest 0..7, rf_in=0; init_busy falls after the 8th.
//  2. RUN, req=2'b01, wr_data0=16'h1234, dest0=3 -> same cycle ack=01, rf_load=1, rf_dest=3, rf_in=16'h1234.
//  3. RUN, req=2'b11 held 4 cycles from rr_ptr=0 -> ack sequence 01,10,01,10; rf_in alternates per source.
//  4. req=2'b10 asserted during INIT -> ack=0 until the first RUN cycle, then ack=10 with dest1/data1.
//  5. rst asserted at INIT cycle 5 -> next cycle rf_load=0, init_busy=1; then a full 8-entry clear from 0.
//  6. Regfile model checks reg0..7 after writes to dest 7 (data 16'hFFFF) and dest 0 (data 16'h0001) -> reads match.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: clears every entry after reset, then round-robins between writers.
// Zero-latency combinational grant; a loser keeps its req/dest/data steady until it sees ack.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*tag_width-1:0]  wr_dest,
  input  logic [NUM_REQ*data_width-1:0] wr_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          rf_load,
  output logic [tag_width-1:0]          rf_dest,
  output logic [data_width-1:0]         rf_in,
  output logic                          init_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               state_q,   state_d;
  logic [tag_width-1:0] clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0]     rr_ptr_q,  rr_ptr_d;

  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     cand;

  // Scan candidates starting at rr_ptr; the first requesting one wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && cand == PTR_W'(i) && req[i]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    ack       = '0;
    rf_load   = 1'b0;
    rf_dest   = '0;
    rf_in     = '0;
    init_busy = 1'b0;
    if (rst) begin
      init_busy = 1'b1;
    end else if (state_q == S_INIT) begin
      init_busy = 1'b1;
      rf_load   = 1'b1;
      rf_dest   = clr_cnt_q;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) state_d = S_RUN;
    end else if (found) begin
      rf_load = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (winner == PTR_W'(i)) begin
          ack[i]  = 1'b1;
          rf_dest = wr_dest[i*tag_width +: tag_width];
          rf_in   = wr_data[i*data_width +: data_width];
        end
      end
      rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized requesters
// checked against a cycle-level reference model and a register-file memory.
module tb_regfile_write_arbiter;

  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int TW   = 3;
  localparam int NREG = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*TW-1:0] wr_dest;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    ack;
  logic            rf_load;
  logic [TW-1:0]   rf_dest;
  logic [DW-1:0]   rf_in;
  logic            init_busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] rf_mem [NREG];

  // Reference model state: remaining clear cycles and round-robin start.
  int m_init_left = NREG;
  int m_rr        = 0;

  regfile_write_arbiter #(.NUM_REQ(N), .data_width(DW), .tag_width(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_dest(wr_dest), .wr_data(wr_data),
    .ack(ack), .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_load) rf_mem[rf_dest] <= rf_in;

  function automatic logic [N+TW+DW+1:0] predict(input logic r_rst, input logic [N-1:0] r,
                                                 output int win);
    logic [N-1:0]  e_ack  = '0;
    logic          e_load = 1'b0;
    logic [TW-1:0] e_dest = '0;
    logic [DW-1:0] e_in   = '0;
    logic          e_busy = 1'b1;
    win = -1;
    if (!r_rst) begin
      if (m_init_left > 0) begin
        e_load = 1'b1;
        e_dest = TW'(NREG - m_init_left);
      end else begin
        e_busy = 1'b0;
        for (int k = 0; k < N; k++)
          if (win < 0 && r[(m_rr + k) % N]) win = (m_rr + k) % N;
        if (win >= 0) begin
          e_ack[win] = 1'b1;
          e_load     = 1'b1;
          e_dest     = wr_dest[win*TW +: TW];
          e_in       = wr_data[win*DW +: DW];
        end
      end
    end
    return {e_ack, e_load, e_dest, e_in, e_busy};
  endfunction

  function automatic void commit(input logic r_rst, input int win);
    if (r_rst) begin
      m_init_left = NREG;
      m_rr        = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (win >= 0) begin
      m_rr = (win + 1) % N;
    end
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [N+TW+DW+1:0] exp;
    rst = 1'b1; req = '0; wr_dest = '0; wr_data = '0;
    @(negedge clk);
    exp = {2'b00, 1'b0, 3'd0, 16'h0000, 1'b1};
    n_cmp++;
    if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
      n_bad++; $display("FAIL reset_out: got %h want %h", {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
    end
    clk_step();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      exp = {2'b00, 1'b1, TW'(i), 16'h0000, 1'b1};
      n_cmp++;
      if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
        n_bad++; $display("FAIL clear_seq[%0d]: got %h want %h", i, {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
      end
      clk_step();
    end
    @(negedge clk);
    exp = '0;
    n_cmp++;
    if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
      n_bad++; $display("FAIL first_run_idle: got %h want %h", {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
    end
    clk_step();
  endtask

  task automatic test_single();
    logic [N+TW+DW+1:0] exp;
    req = 2'b01; wr_dest = {3'd0, 3'd3}; wr_data = {16'h0000, 16'h1234};
    @(negedge clk);
    exp = {2'b01, 1'b1, 3'd3, 16'h1234, 1'b0};
    n_cmp++;
    if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
      n_bad++; $display("FAIL single_req0: got %h want %h", {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
    end
    clk_step();
    req = 2'b10; wr_dest = {3'd6, 3'd0}; wr_data = {16'hCAFE, 16'h0000};
    @(negedge clk);
    exp = {2'b10, 1'b1, 3'd6, 16'hCAFE, 1'b0};
    n_cmp++;
    if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
      n_bad++; $display("FAIL single_req1: got %h want %h", {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
    end
    clk_step();
    req = '0;
  endtask

  task automatic test_alternate();
    logic [N+TW+DW+1:0] exp;
    req = 2'b11; wr_dest = {3'd2, 3'd1}; wr_data = {16'h5555, 16'hAAAA};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = (i % 2 == 0) ? {2'b01, 1'b1, 3'd1, 16'hAAAA, 1'b0} : {2'b10, 1'b1, 3'd2, 16'h5555, 1'b0};
      n_cmp++;
      if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
        n_bad++; $display("FAIL alternate[%0d]: got %h want %h", i, {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
      end
      clk_step();
    end
    req = '0;
    @(negedge clk);
    exp = '0;
    n_cmp++;
    if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
      n_bad++; $display("FAIL idle_after_alt: got %h want %h", {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
    end
    clk_step();
  endtask

  task automatic test_req_during_init();
    logic [N+TW+DW+1:0] exp;
    rst = 1'b1; req = 2'b10; wr_dest = {3'd5, 3'd0}; wr_data = {16'hBEEF, 16'h0000};
    clk_step();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      exp = {2'b00, 1'b1, TW'(i), 16'h0000, 1'b1};
      n_cmp++;
      if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
        n_bad++; $display("FAIL init_ignores_req[%0d]: got %h want %h", i, {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
      end
      clk_step();
    end
    @(negedge clk);
    exp = {2'b10, 1'b1, 3'd5, 16'hBEEF, 1'b0};
    n_cmp++;
    if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
      n_bad++; $display("FAIL first_run_grant: got %h want %h", {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
    end
    clk_step();
    req = '0;
  endtask

  task automatic test_reset_mid_init();
    logic [N+TW+DW+1:0] exp;
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) clk_step();
    rst = 1'b1;
    @(negedge clk);
    exp = {2'b00, 1'b0, 3'd0, 16'h0000, 1'b1};
    n_cmp++;
    if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
      n_bad++; $display("FAIL mid_init_rst: got %h want %h", {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
    end
    clk_step();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      exp = {2'b00, 1'b1, TW'(i), 16'h0000, 1'b1};
      n_cmp++;
      if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
        n_bad++; $display("FAIL reclear[%0d]: got %h want %h", i, {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
      end
      clk_step();
    end
    @(negedge clk);
    n_cmp++;
    if (init_busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_after_reclear: got %b want 0", init_busy);
    end
    clk_step();
  endtask

  task automatic test_regfile();
    logic [DW-1:0] exp_mem [NREG];
    for (int i = 0; i < NREG; i++) exp_mem[i] = '0;
    req = 2'b11; wr_dest = {3'd7, 3'd7}; wr_data = {16'hFFFF, 16'h1111};
    clk_step();
    req = 2'b10;
    clk_step();
    exp_mem[7] = 16'hFFFF;
    req = 2'b01; wr_dest = {3'd0, 3'd0}; wr_data = {16'h0000, 16'h0001};
    clk_step();
    exp_mem[0] = 16'h0001;
    req = '0;
    clk_step();
    for (int i = 0; i < NREG; i++) begin
      n_cmp++;
      if (rf_mem[i] !== exp_mem[i]) begin
        n_bad++; $display("FAIL regfile[%0d]: got %h want %h", i, rf_mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0]       pend;
    logic [TW-1:0]      pd   [N];
    logic [DW-1:0]      pdat [N];
    int                 waitc[N];
    logic [N+TW+DW+1:0] exp;
    logic [N-1:0]       seen_ack;
    int                 win;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      pd[i] = '0; pdat[i] = '0; waitc[i] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = (cyc == 0) || ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1; pd[i] = TW'($urandom); pdat[i] = DW'($urandom); waitc[i] = 0;
        end
        wr_dest[i*TW +: TW] = pd[i];
        wr_data[i*DW +: DW] = pdat[i];
      end
      req = pend;
      @(negedge clk);
      exp = predict(rst, req, win);
      n_cmp++;
      if ({ack, rf_load, rf_dest, rf_in, init_busy} !== exp) begin
        n_bad++; $display("FAIL random cyc %0d req %b: got %h want %h", cyc, req,
                          {ack, rf_load, rf_dest, rf_in, init_busy}, exp);
      end
      seen_ack = ack;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && seen_ack[i] === 1'b1) begin
          n_cmp++;
          if (waitc[i] > N - 1) begin
            n_bad++; $display("FAIL fairness req%0d: waited %0d grants, limit %0d", i, waitc[i], N - 1);
          end
        end else if (pend[i] && seen_ack !== '0) begin
          waitc[i]++;
        end
      end
      commit(rst, win);
      clk_step();
      for (int i = 0; i < N; i++)
        if (rst || seen_ack[i] === 1'b1) pend[i] = 1'b0;
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; wr_dest = '0; wr_data = '0;
    test_reset();
    test_single();
    test_alternate();
    test_req_during_init();
    test_reset_mid_init();
    test_regfile();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
